chip_wr_seq: RTL and testbench



---
 rtl/chip_if_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/chip_wr_seq.sv | 172 +++++++++++++++++
 tb/tb_chip_wr_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_if_pkg.sv
// Shared definitions for the analog chip pin interface: widths, write-sequencer
// state encoding and the {wen,wbuf,cal} pin modes used by both chip-side paths.
package chip_if_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } wr_state_e;

    // Pin modes packed as {wen, wbuf, cal}
    localparam logic [2:0] PIN_MODE_IDLE     = 3'b000;
    localparam logic [2:0] PIN_MODE_ARRAY_WR = 3'b100;
    localparam logic [2:0] PIN_MODE_IOBUF_WR = 3'b110;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = x;
        if (y > m) begin
            m = y;
        end else begin
            m = m;
        end
        if (z > m) begin
            m = z;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request FIFO with registered occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == CNT_ZERO);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Entry storage carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/chip_wr_seq.sv
// Write-side sequencer for the analog chip: queues host writes and replays each
// onto a/d/wen/wbuf/cal with programmable setup, pulse and hold timing.
module chip_wr_seq
    import chip_if_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 4,
    parameter int T_HOLD     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_data,
    input  logic          i_req_buf,
    input  logic          i_req_cal,
    output logic          o_busy,
    output logic          o_wr_done,
    output logic [AW-1:0] o_a,
    output logic [DW-1:0] o_d,
    output logic          o_wen,
    output logic          o_wbuf,
    output logic          o_cal
);
    localparam int CW   = $clog2(max3(T_SETUP, T_PULSE, T_HOLD)) + 1;
    localparam int FW   = AW + DW + 2;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);

    wr_state_e       r_state;
    wr_state_e       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_load;
    logic            w_to_idle;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic [CNTW-1:0] w_count;
    logic [FW-1:0]   w_push_data;
    logic [FW-1:0]   w_head;
    logic            r_rdy_en;
    logic [AW-1:0]   r_a;
    logic [DW-1:0]   r_d;
    logic            r_wen;
    logic            r_wbuf;
    logic            r_cal;
    logic            r_wr_done;

    // Ready is held low through reset and comes up on the first clock after release
    assign o_req_ready = r_rdy_en & ~w_full;
    assign w_push      = i_req_valid & o_req_ready;
    assign w_push_data = {i_req_addr, i_req_data, i_req_buf, i_req_cal};
    assign o_busy      = (w_count != CNTW'(0)) || (r_state != ST_IDLE);
    assign o_wr_done   = r_wr_done;
    assign o_a         = r_a;
    assign o_d         = r_d;
    assign o_wen       = r_wen;
    assign o_wbuf      = r_wbuf;
    assign o_cal       = r_cal;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state, phase counter and FIFO pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_to_idle   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = PULSE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_ZERO) begin
                    // Back-to-back: a queued request goes straight to SETUP
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = SETUP_LD;
                    end else begin
                        w_to_idle   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered chip pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_rdy_en  <= 1'b0;
            r_a       <= AW'(0);
            r_d       <= DW'(0);
            r_wen     <= 1'b0;
            r_wbuf    <= 1'b0;
            r_cal     <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdy_en  <= 1'b1;
            r_wen     <= (w_state_nxt == ST_PULSE);
            // Fires during the final HOLD cycle
            r_wr_done <= (w_state_nxt == ST_HOLD) && (w_cnt_nxt == CNT_ZERO);
            if (w_load) begin
                {r_a, r_d, r_wbuf, r_cal} <= w_head;
            end else if (w_to_idle) begin
                r_wbuf <= PIN_MODE_IDLE[1];
                r_cal  <= PIN_MODE_IDLE[0];
            end else begin
                r_a    <= r_a;
                r_d    <= r_d;
                r_wbuf <= r_wbuf;
                r_cal  <= r_cal;
            end
        end
    end

endmodule

// File: tb/tb_chip_wr_seq.sv
// Directed scoreboard bench for chip_wr_seq: default timing instance plus a
// second instance with single-cycle setup/pulse/hold.
module tb_chip_wr_seq;
    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_buf = 1'b0, req_cal = 1'b0;
    logic [8:0]  req_addr = 9'd0;
    logic [15:0] req_data = 16'd0;
    logic        req_ready, busy, wr_done, wen, wbuf, cal;
    logic [8:0]  a;
    logic [15:0] d;

    logic        f_valid = 1'b0, f_buf = 1'b0, f_cal = 1'b0;
    logic [8:0]  f_addr = 9'd0;
    logic [15:0] f_data = 16'd0;
    logic        f_ready, f_busy, f_wr_done, f_wen, f_wbuf, f_cal_o;
    logic [8:0]  f_a;
    logic [15:0] f_d;

    chip_wr_seq dut (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_data(req_data), .i_req_buf(req_buf), .i_req_cal(req_cal),
        .o_busy(busy), .o_wr_done(wr_done), .o_a(a), .o_d(d), .o_wen(wen), .o_wbuf(wbuf), .o_cal(cal)
    );

    chip_wr_seq #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .i_req_valid(f_valid), .o_req_ready(f_ready),
        .i_req_addr(f_addr), .i_req_data(f_data), .i_req_buf(f_buf), .i_req_cal(f_cal),
        .o_busy(f_busy), .o_wr_done(f_wr_done), .o_a(f_a), .o_d(f_d), .o_wen(f_wen), .o_wbuf(f_wbuf), .o_cal(f_cal_o)
    );

    int checks = 0;
    int failures = 0;
    logic [26:0] sb[$];
    logic [26:0] fsb[$];
    time last_push_t, t0, t_idle, f_t0, f_last_done_t;
    int stall_total, done_cnt = 0, f_done_cnt = 0, f_wen_cycles = 0, done_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [8:0] ad, input logic [15:0] da, input logic bf, input logic cl);
        int n;
        n = 0;
        req_valid = 1'b1; req_addr = ad; req_data = da; req_buf = bf; req_cal = cl;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("push_timeout", 64'(n < 100), 64'd1);
        @(posedge clk);
        sb.push_back({ad, da, bf, cl});
        last_push_t = $time;
        stall_total += n;
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output time t);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 600) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", 64'(n < 600), 64'd1);
        t = $time - 1;
    endtask

    // Pin-timing monitor and scoreboard for the default-timing instance
    logic [26:0] prev_pins, cur_pins, exp_v;
    logic prev_wen, chg_seen, in_hold, chg_after_fall;
    int wen_len, hold_len, since_chg;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", 64'({a, d, wen, wbuf, cal, busy, wr_done, req_ready}), 64'd0);
            prev_pins = 27'd0; prev_wen = 1'b0; chg_seen = 1'b0; in_hold = 1'b0;
            chg_after_fall = 1'b0; wen_len = 0; hold_len = 0; since_chg = 0;
        end else begin
            cur_pins = {a, d, wbuf, cal};
            if (cur_pins !== prev_pins) begin
                since_chg = 1; chg_seen = 1'b1;
                if (in_hold) chg_after_fall = 1'b1;
            end else begin
                since_chg++;
            end
            if (wen) begin
                chk("pins_stable_in_pulse", 64'(cur_pins), 64'(prev_pins));
                wen_len++;
            end
            if (wen && !prev_wen && chg_seen) begin
                chk("setup_len", 64'(since_chg), 64'(T_SETUP + 1));
                chg_seen = 1'b0;
            end
            if (!wen && prev_wen) begin
                chk("pulse_len", 64'(wen_len), 64'(T_PULSE));
                wen_len = 0; in_hold = 1'b1; hold_len = 0; chg_after_fall = 1'b0;
            end
            if (in_hold && !wen) hold_len++;
            if (wr_done) begin
                chk("hold_len", 64'(hold_len), 64'(T_HOLD));
                chk("hold_stable", 64'(chg_after_fall), 64'd0);
                if (sb.size() == 0) begin
                    chk("spurious_wr_done", 64'd1, 64'd0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("write_pins", 64'(cur_pins), 64'(exp_v));
                end
                done_cnt++;
                in_hold = 1'b0;
            end
            if (!busy) chk("idle_pins", 64'({wen, wbuf, cal}), 64'd0);
            prev_pins = cur_pins;
            prev_wen = wen;
        end
    end

    // Monitor for the single-cycle-timing instance
    logic f_prev_wen;
    logic [26:0] f_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            f_prev_wen = 1'b0;
        end else begin
            if (f_wen) begin
                chk("fast_pulse_len", 64'(f_prev_wen), 64'd0);
                f_wen_cycles++;
            end
            if (f_wr_done) begin
                if (fsb.size() == 0) begin
                    chk("fast_spurious_done", 64'd1, 64'd0);
                end else begin
                    f_exp = fsb.pop_front();
                    chk("fast_pins", 64'({f_a, f_d, f_wbuf, f_cal_o}), 64'(f_exp));
                end
                if (f_done_cnt == 0) chk("fast_first_done", 64'($time - f_t0), 64'd35);
                else chk("fast_rate", 64'(($time - f_last_done_t) / 10), 64'd3);
                f_last_done_t = $time;
                f_done_cnt++;
            end
            f_prev_wen = f_wen;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(req_ready), 64'd1);
        chk("busy_after_reset", 64'(busy), 64'd0);

        // Single write
        send(9'h05A, 16'hBEEF, 1'b0, 1'b0);
        t0 = last_push_t;
        wait_idle(t_idle);
        chk("single_duration", 64'((t_idle - t0) / 10), 64'd9);
        chk("single_done_cnt", 64'(done_cnt), 64'd1);

        // Back-to-back: five consecutive pushes fill the FIFO
        stall_total = 0;
        for (int i = 0; i < 5; i++) begin
            send(9'(256 + i), 16'(40960 + i), 1'(i & 1), 1'b0);
            if (i == 0) t0 = last_push_t;
        end
        chk("ready_when_full", 64'(req_ready), 64'd0);
        chk("b2b_no_stall", 64'(stall_total), 64'd0);
        wait_idle(t_idle);
        chk("b2b_duration", 64'((t_idle - t0) / 10), 64'd41);
        chk("b2b_done_cnt", 64'(done_cnt), 64'd6);

        // Continuous valid against a full FIFO: 16 writes
        stall_total = 0;
        for (int i = 0; i < 16; i++) begin
            send(9'(32 + i), 16'(49152 + i), 1'(i & 1), 1'(i >> 1 & 1));
            if (i == 0) t0 = last_push_t;
        end
        chk("full_stall_cycles", 64'(stall_total), 64'd75);
        wait_idle(t_idle);
        chk("full_duration", 64'((t_idle - t0) / 10), 64'd129);
        chk("full_done_cnt", 64'(done_cnt), 64'd22);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        // iobuf write with cal asserted
        send(9'h1A3, 16'h1234, 1'b1, 1'b1);
        n = 0;
        while (wen !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("iobuf_wen_seen", 64'(n < 50), 64'd1);
        chk("iobuf_pulse_pins", 64'({wen, wbuf, cal}), 64'h7);
        wait_idle(t_idle);
        chk("iobuf_idle_pins", 64'({wen, wbuf, cal}), 64'h0);
        chk("iobuf_done_cnt", 64'(done_cnt), 64'd23);

        // Reset in the second PULSE cycle with two requests queued
        send(9'h0F0, 16'h0F00, 1'b0, 1'b0);
        send(9'h0F1, 16'h0F11, 1'b1, 1'b0);
        send(9'h0F2, 16'h0F22, 1'b0, 1'b1);
        n = 0;
        while (wen !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("abort_wen_seen", 64'(n < 50), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wen_async", 64'(wen), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        sb.delete();
        done_before = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_busy_after", 64'(busy), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'(done_before));
        chk("abort_no_replay", 64'({busy, wen}), 64'd0);

        // Single-cycle timing instance: one write every 3 cycles
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1; f_addr = 9'(17 + i); f_data = 16'(21760 + i);
            f_buf = 1'(i & 1); f_cal = 1'b1;
            chk("fast_ready", 64'(f_ready), 64'd1);
            @(posedge clk);
            fsb.push_back({f_addr, f_data, f_buf, f_cal});
            if (i == 0) f_t0 = $time;
            #1;
        end
        f_valid = 1'b0;
        n = 0;
        while (f_busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("fast_idle_timeout", 64'(n < 100), 64'd1);
        chk("fast_duration", 64'(($time - 1 - f_t0) / 10), 64'd10);
        chk("fast_done_cnt", 64'(f_done_cnt), 64'd3);
        chk("fast_wen_cycles", 64'(f_wen_cycles), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
